// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, optional even/odd parity, 1-2 stop bits.
// Latency: start bit drives the line in the first cycle after the accepting edge.
// Backpressure: in_ready is high only in IDLE; data is latched on accept and the source is ignored until the frame ends.
module uart_tx_cfg #(
    parameter int BAUD_DIV  = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 uart_txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_DISABLED = 3'd0,
        S_IDLE     = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_PAR      = 3'd4,
        S_STOP     = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 done_q, done_d;
    logic                 baud_end;

    assign baud_end = (cnt_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q <= S_DISABLED;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            S_DISABLED: state_d = S_IDLE;
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    par_d   = (PARITY == 2) ? ~(^in_data) : (^in_data);
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    // LSB is always on the line; shift after each bit period
                    shreg_d = shreg_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PAR: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_DISABLED;
        endcase
    end

    // Outputs decode registered state only: no input-to-output paths
    always_comb begin
        uart_txd = 1'b1;
        case (state_q)
            S_START: uart_txd = 1'b0;
            S_DATA:  uart_txd = shreg_q[0];
            S_PAR:   uart_txd = par_q;
            default: uart_txd = 1'b1;
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PAR)   || (state_q == S_STOP);
    assign tx_done  = done_q;

endmodule
